id_stage_param: RTL and testbench
=================================

// Module: id_stage_param
// PURPOSE
//  Parametrised MIPS instruction-decode stage: register file, control decode, immediate extension,
//  load-use hazard detection and registered ID/EX pipeline outputs. Sits between the IF/ID and ID/EX
//  boundaries. Adds write-read bypass, flush, bubble insertion, zero-extend immediates, configurable width.
// PARAMETERS
//  DATA_WIDTH  32  register/data width; immediates extend to this width
//  NUM_REGS    32  implemented registers (2..32); addr >= NUM_REGS reads 0, writes dropped
//  ZERO_REG    1   1: register 0 hardwired to 0 (writes ignored)
// PORTS
//  clk                  in   1                 rising-edge clock
//  rst                  in   1                 synchronous, active-high reset
//  i_instruction        in   32                IF/ID instruction {op[31:26],rs,rt,rd/imm}
//  i_write_data         in   DATA_WIDTH        WB write data
//  i_mem_wb_rd          in   5                 WB destination register
//  i_mem_wb_RegWrite    in   1                 WB write enable
//  i_id_ex_rt           in   5                 rt of instruction currently in EX
//  i_id_ex_MemRead      in   1                 instruction in EX is a load
//  i_flush              in   1                 squash current decode (taken branch/jump)
//  o_PCWrite            out  1                 0 = hold PC (combinational)
//  o_if_id_write        out  1                 0 = hold IF/ID (combinational)
//  o_RegDst,o_ALUSrc,o_Branch,o_MemRead,o_MemWrite,o_RegWrite,o_MemtoReg  out 1 each  registered ctrl
//  o_ALUOp              out  2                 00 add, 01 sub, 10 funct, 11 logical-imm
//  o_read_data_1/2      out  DATA_WIDTH        registered rs/rt operands
//  o_immediate_data_ext out  DATA_WIDTH        registered extended immediate
//  o_rs,o_rt,o_rd       out  5 each            registered register fields
//  o_rf_regs            out  32*DATA_WIDTH     debug dump, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
//  - Reset: all regfile entries 0; every registered output 0; no write occurs in reset cycle.
//  - Regfile write on rising clk when RegWrite & rd!=0 (if ZERO_REG) & rd<NUM_REGS.
//  - Read bypass: if WB writes reg X this cycle and rs/rt==X, decode uses i_write_data (same cycle).
//  - Decode (op): 000000 R: RegDst=1,ALUOp=10,RegWrite=1. 100011 LW: ALUSrc,MemRead,RegWrite,MemtoReg,
//    ALUOp=00. 101011 SW: ALUSrc,MemWrite,ALUOp=00. 000100 BEQ: Branch,ALUOp=01. 001000 ADDI: ALUSrc,
//    RegWrite,ALUOp=00. 001100 ANDI/001101 ORI: ALUSrc,RegWrite,ALUOp=11. Others: all ctrl 0 (NOP).
//  - Immediate: sign-extend imm[15:0] to DATA_WIDTH; zero-extend for ANDI/ORI.
//  - Hazard: stall = i_id_ex_MemRead & i_id_ex_rt!=0 & (i_id_ex_rt==rs | (i_id_ex_rt==rt & op uses rt:
//    R,SW,BEQ)). stall -> o_PCWrite=0, o_if_id_write=0 same cycle; else both 1. Both 1 during rst.
//  - ID/EX update each rising clk, priority rst > i_flush > stall > normal.
//    flush or stall: all ctrl outputs 0 next cycle (bubble); data/field outputs still load (don't-care).
//  - Latency: instruction presented in cycle N appears on registered outputs after edge N.
//  - Stall persists only while condition holds; one load-use gives exactly one bubble.
//  - Flush and stall together: bubble inserted, o_PCWrite/o_if_id_write still 0 for that cycle.
//  - Reset mid-operation clears pipeline outputs and regfile in one edge.
// TESTING
//  1 Write reg i = i*10 for i=0..31, then read rs=i,rt=i+2 -> reg0 reads 0; rs=5 gives 50; rt>=NUM_REGS gives 0.
//  2 WB writes r7=0xDEAD while decoding rs=7 same cycle -> o_read_data_1=0xDEAD after the edge.
//  3 id_ex_MemRead=1, id_ex_rt=3, decode R-type rt=3 -> PCWrite=if_id_write=0, next ctrl all 0.
//    Same with SW rs=3 stalls; ADDI rt=3 does not.
//  4 ADDI imm=0xFFC2 -> ext=0xFFFFFFC2; ORI imm=0xFFC2 -> 0x0000FFC2; imm 28089 -> 0x00006DB9.
//  5 LW decoded with i_flush=1 -> next cycle MemRead=RegWrite=0; with DATA_WIDTH=16 repeat test 4 widths.
//  6 Assert rst mid-stream after regs written -> next edge all outputs 0 and o_rf_regs all 0.

Source files
------------

// File: rtl/id_stage_param.sv
// MIPS instruction-decode stage: register file with WB bypass, control decode, immediate
// extension, load-use hazard detection and the registered ID/EX pipeline boundary.
module id_stage_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  i_instruction,
    input  logic [DATA_WIDTH-1:0]        i_write_data,
    input  logic [4:0]                   i_mem_wb_rd,
    input  logic                         i_mem_wb_RegWrite,
    input  logic [4:0]                   i_id_ex_rt,
    input  logic                         i_id_ex_MemRead,
    input  logic                         i_flush,
    output logic                         o_PCWrite,
    output logic                         o_if_id_write,
    output logic                         o_RegDst,
    output logic                         o_ALUSrc,
    output logic                         o_Branch,
    output logic                         o_MemRead,
    output logic                         o_MemWrite,
    output logic                         o_RegWrite,
    output logic                         o_MemtoReg,
    output logic [1:0]                   o_ALUOp,
    output logic [DATA_WIDTH-1:0]        o_read_data_1,
    output logic [DATA_WIDTH-1:0]        o_read_data_2,
    output logic [DATA_WIDTH-1:0]        o_immediate_data_ext,
    output logic [4:0]                   o_rs,
    output logic [4:0]                   o_rt,
    output logic [4:0]                   o_rd,
    output logic [32*DATA_WIDTH-1:0]     o_rf_regs
);

    localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);
    localparam logic [DATA_WIDTH-1:0] IMM_HI_MASK = ~DATA_WIDTH'(32'h0000_FFFF);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [1:0] alu_op;
    } ctrl_t;

    logic [5:0]            op;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [15:0]           imm;
    logic [DATA_WIDTH-1:0] rf_q [32];
    logic                  wb_we;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic                  uses_rt;
    logic                  zero_ext;
    logic                  stall;
    ctrl_t                 ctrl_d;
    ctrl_t                 ctrl_q;
    logic [DATA_WIDTH-1:0] rd1_q;
    logic [DATA_WIDTH-1:0] rd2_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [4:0]            rs_q;
    logic [4:0]            rt_q;
    logic [4:0]            rd_q;

    assign op  = i_instruction[31:26];
    assign rs  = i_instruction[25:21];
    assign rt  = i_instruction[20:16];
    assign rd  = i_instruction[15:11];
    assign imm = i_instruction[15:0];

    // Writes to r0 (when hardwired) or unimplemented registers are dropped.
    assign wb_we = i_mem_wb_RegWrite
                 && !(ZERO_REG && (i_mem_wb_rd == 5'd0))
                 && ({1'b0, i_mem_wb_rd} < NUM_REGS_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we) begin
            rf_q[i_mem_wb_rd] <= i_write_data;
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_dump
        assign o_rf_regs[g*DATA_WIDTH +: DATA_WIDTH] = rf_q[g];
    end

    // Same-cycle WB bypass; unwritten entries stay 0 so out-of-range reads return 0.
    assign rs_data = (wb_we && (i_mem_wb_rd == rs)) ? i_write_data : rf_q[rs];
    assign rt_data = (wb_we && (i_mem_wb_rd == rt)) ? i_write_data : rf_q[rt];

    always_comb begin
        ctrl_d   = '0;
        uses_rt  = 1'b0;
        zero_ext = 1'b0;
        unique case (op)
            OP_R: begin
                ctrl_d.reg_dst   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = 2'b10;
                uses_rt          = 1'b1;
            end
            OP_LW: begin
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                uses_rt          = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d.branch = 1'b1;
                ctrl_d.alu_op = 2'b01;
                uses_rt       = 1'b1;
            end
            OP_ADDI: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = 2'b11;
                zero_ext         = 1'b1;
            end
            default: ;
        endcase
    end

    // Sign extension done by OR-ing the upper mask so DATA_WIDTH == 16 needs no special case.
    always_comb begin
        imm_ext = DATA_WIDTH'(imm);
        if (!zero_ext && imm[15]) begin
            imm_ext = imm_ext | IMM_HI_MASK;
        end
    end

    assign stall = i_id_ex_MemRead && (i_id_ex_rt != 5'd0)
                 && ((i_id_ex_rt == rs) || ((i_id_ex_rt == rt) && uses_rt));

    assign o_PCWrite     = rst || !stall;
    assign o_if_id_write = rst || !stall;

    // ID/EX register: flush or stall inserts a bubble by clearing control only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= (i_flush || stall) ? ctrl_t'('0) : ctrl_d;
            rd1_q  <= rs_data;
            rd2_q  <= rt_data;
            imm_q  <= imm_ext;
            rs_q   <= rs;
            rt_q   <= rt;
            rd_q   <= rd;
        end
    end

    assign o_RegDst             = ctrl_q.reg_dst;
    assign o_ALUSrc             = ctrl_q.alu_src;
    assign o_Branch             = ctrl_q.branch;
    assign o_MemRead            = ctrl_q.mem_read;
    assign o_MemWrite           = ctrl_q.mem_write;
    assign o_RegWrite           = ctrl_q.reg_write;
    assign o_MemtoReg           = ctrl_q.mem_to_reg;
    assign o_ALUOp              = ctrl_q.alu_op;
    assign o_read_data_1        = rd1_q;
    assign o_read_data_2        = rd2_q;
    assign o_immediate_data_ext = imm_q;
    assign o_rs                 = rs_q;
    assign o_rt                 = rt_q;
    assign o_rd                 = rd_q;

endmodule

// File: tb/tb_id_stage_param.sv
// Bench for id_stage_param: a 32-bit/32-reg instance and a 16-bit/16-reg instance driven in
// lockstep, checked against an array-based reference model of the decode stage.
module tb_id_stage_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [4:0]  ex_rt;
    logic        ex_mr;
    logic        flush;

    logic          a_pcw, a_ifw, b_pcw, b_ifw;
    logic [8:0]    a_ctl, b_ctl;
    logic [14:0]   a_fld, b_fld;
    logic [31:0]   a_rd1, a_rd2, a_imm;
    logic [15:0]   b_rd1, b_rd2, b_imm;
    logic [1023:0] a_rf;
    logic [511:0]  b_rf;

    logic [31:0] m32 [32];
    logic [15:0] m16 [32];
    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_NOP = 6'h3F;

    always #5 clk = ~clk;

    id_stage_param dut32 (
        .clk(clk), .rst(rst), .i_instruction(instr), .i_write_data(wdata),
        .i_mem_wb_rd(wb_rd), .i_mem_wb_RegWrite(wb_we), .i_id_ex_rt(ex_rt),
        .i_id_ex_MemRead(ex_mr), .i_flush(flush),
        .o_PCWrite(a_pcw), .o_if_id_write(a_ifw),
        .o_RegDst(a_ctl[8]), .o_ALUSrc(a_ctl[7]), .o_Branch(a_ctl[6]), .o_MemRead(a_ctl[5]),
        .o_MemWrite(a_ctl[4]), .o_RegWrite(a_ctl[3]), .o_MemtoReg(a_ctl[2]), .o_ALUOp(a_ctl[1:0]),
        .o_read_data_1(a_rd1), .o_read_data_2(a_rd2), .o_immediate_data_ext(a_imm),
        .o_rs(a_fld[14:10]), .o_rt(a_fld[9:5]), .o_rd(a_fld[4:0]), .o_rf_regs(a_rf)
    );

    id_stage_param #(.DATA_WIDTH(16), .NUM_REGS(16), .ZERO_REG(1'b1)) dut16 (
        .clk(clk), .rst(rst), .i_instruction(instr), .i_write_data(wdata[15:0]),
        .i_mem_wb_rd(wb_rd), .i_mem_wb_RegWrite(wb_we), .i_id_ex_rt(ex_rt),
        .i_id_ex_MemRead(ex_mr), .i_flush(flush),
        .o_PCWrite(b_pcw), .o_if_id_write(b_ifw),
        .o_RegDst(b_ctl[8]), .o_ALUSrc(b_ctl[7]), .o_Branch(b_ctl[6]), .o_MemRead(b_ctl[5]),
        .o_MemWrite(b_ctl[4]), .o_RegWrite(b_ctl[3]), .o_MemtoReg(b_ctl[2]), .o_ALUOp(b_ctl[1:0]),
        .o_read_data_1(b_rd1), .o_read_data_2(b_rd2), .o_immediate_data_ext(b_imm),
        .o_rs(b_fld[14:10]), .o_rt(b_fld[9:5]), .o_rd(b_fld[4:0]), .o_rf_regs(b_rf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Control table {RegDst,ALUSrc,Branch,MemRead,MemWrite,RegWrite,MemtoReg,ALUOp[1:0]}.
    function automatic logic [8:0] dec(input logic [5:0] op);
        case (op)
            OP_R:            return 9'b1_0_0_0_0_1_0_10;
            OP_LW:           return 9'b0_1_0_1_0_1_1_00;
            OP_SW:           return 9'b0_1_0_0_1_0_0_00;
            OP_BEQ:          return 9'b0_0_1_0_0_0_0_01;
            OP_ADDI:         return 9'b0_1_0_0_0_1_0_00;
            OP_ANDI, OP_ORI: return 9'b0_1_0_0_0_1_0_11;
            default:         return 9'b0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // One decode cycle; entered and left on a falling edge.
    task automatic cycle(input string tag, input logic [31:0] in, input logic we,
                         input logic [4:0] wrd, input logic [31:0] wd, input logic mr,
                         input logic [4:0] ert, input logic fl, input logic rs_in);
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic        stall, we32, we16, u_rt;
        logic [8:0]  ctl;
        logic [31:0] e1a, e2a, eia;
        logic [15:0] e1b, e2b, eib;
        int          v;
        instr = in; wb_we = we; wb_rd = wrd; wdata = wd; ex_mr = mr; ex_rt = ert;
        flush = fl; rst = rs_in;
        op = in[31:26]; rs = in[25:21]; rt = in[20:16];
        u_rt  = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
        stall = mr && (ert != 5'd0) && ((ert == rs) || ((ert == rt) && u_rt));
        ctl   = (fl || stall) ? 9'b0 : dec(op);
        we32  = we && (wrd != 5'd0);
        we16  = we32 && (wrd < 5'd16);
        e1a = (we32 && wrd == rs) ? wd : m32[rs];
        e2a = (we32 && wrd == rt) ? wd : m32[rt];
        e1b = (we16 && wrd == rs) ? wd[15:0] : m16[rs];
        e2b = (we16 && wrd == rt) ? wd[15:0] : m16[rt];
        v = int'(in[15:0]);
        if (op != OP_ANDI && op != OP_ORI && v >= 32768) v = v - 65536;
        eia = 32'(v);
        eib = 16'(v);
        #1;
        chk({tag, ":pcw32"}, 64'(a_pcw), 64'(rs_in || !stall));
        chk({tag, ":ifw32"}, 64'(a_ifw), 64'(rs_in || !stall));
        chk({tag, ":pcw16"}, 64'(b_pcw), 64'(rs_in || !stall));
        chk({tag, ":ifw16"}, 64'(b_ifw), 64'(rs_in || !stall));
        @(posedge clk);
        #1;
        if (rs_in) begin
            for (int i = 0; i < 32; i++) begin
                m32[i] = '0;
                m16[i] = '0;
            end
            ctl = '0; e1a = '0; e2a = '0; eia = '0; e1b = '0; e2b = '0; eib = '0;
            rs = '0; rt = '0;
        end else begin
            if (we32) m32[wrd] = wd;
            if (we16) m16[wrd] = wd[15:0];
        end
        chk({tag, ":ctl32"}, 64'(a_ctl), 64'(ctl));
        chk({tag, ":ctl16"}, 64'(b_ctl), 64'(ctl));
        chk({tag, ":rd1_32"}, 64'(a_rd1), 64'(e1a));
        chk({tag, ":rd2_32"}, 64'(a_rd2), 64'(e2a));
        chk({tag, ":imm32"}, 64'(a_imm), 64'(eia));
        chk({tag, ":rd1_16"}, 64'(b_rd1), 64'(e1b));
        chk({tag, ":rd2_16"}, 64'(b_rd2), 64'(e2b));
        chk({tag, ":imm16"}, 64'(b_imm), 64'(eib));
        chk({tag, ":fld32"}, 64'(a_fld), rs_in ? 64'(0) : 64'({rs, rt, in[15:11]}));
        chk({tag, ":fld16"}, 64'(b_fld), rs_in ? 64'(0) : 64'({rs, rt, in[15:11]}));
        @(negedge clk);
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk({tag, ":rf32"}, 64'(a_rf[i*32 +: 32]), 64'(m32[i]));
            chk({tag, ":rf16"}, 64'(b_rf[i*16 +: 16]), 64'(m16[i]));
        end
    endtask

    initial begin
        logic [5:0] ops [9];
        logic [5:0] op;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_NOP, 6'h02};
        for (int i = 0; i < 32; i++) begin
            m32[i] = '0;
            m16[i] = '0;
        end
        rst = 1'b1; instr = '0; wdata = '0; wb_rd = '0; wb_we = 1'b0;
        ex_rt = '0; ex_mr = 1'b0; flush = 1'b0;
        @(negedge clk);
        cycle("reset", mk(OP_LW, 5'd1, 5'd2, 16'h1234), 1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 1'b0, 1'b1);
        check_rf("reset");

        // Fill reg i with i*10 (r0 write must be ignored), then read rs=i, rt=i+2.
        for (int i = 0; i < 32; i++)
            cycle("fill", mk(OP_NOP, 5'd0, 5'd0, 16'h0), 1'b1, 5'(i), 32'(i * 10),
                  1'b0, 5'd0, 1'b0, 1'b0);
        check_rf("fill");
        for (int i = 0; i < 32; i++)
            cycle("read", mk(OP_R, 5'(i), 5'(i + 2), 16'h2820), 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 1'b0, 1'b0);
        cycle("rs5", mk(OP_R, 5'd5, 5'd20, 16'h0), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("rs5_direct", 64'(a_rd1), 64'd50);
        chk("rt20_16bit_oor", 64'(b_rd2), 64'd0);

        cycle("bypass", mk(OP_R, 5'd7, 5'd7, 16'h0), 1'b1, 5'd7, 32'hDEAD, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("bypass_direct", 64'(a_rd1), 64'hDEAD);

        cycle("haz_r", mk(OP_R, 5'd1, 5'd3, 16'h0), 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0);
        chk("haz_r_bubble", 64'(a_ctl), 64'd0);
        cycle("haz_sw", mk(OP_SW, 5'd3, 5'd9, 16'h4), 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0);
        cycle("haz_addi", mk(OP_ADDI, 5'd1, 5'd3, 16'h4), 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0);
        cycle("haz_r0", mk(OP_R, 5'd0, 5'd0, 16'h0), 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 1'b0);
        cycle("haz_beq", mk(OP_BEQ, 5'd2, 5'd4, 16'h8), 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 1'b0);

        cycle("imm_addi", mk(OP_ADDI, 5'd1, 5'd2, 16'hFFC2), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("imm_addi_direct", 64'(a_imm), 64'hFFFF_FFC2);
        cycle("imm_ori", mk(OP_ORI, 5'd1, 5'd2, 16'hFFC2), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("imm_ori_direct", 64'(a_imm), 64'h0000_FFC2);
        cycle("imm_pos", mk(OP_LW, 5'd1, 5'd2, 16'd28089), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("imm_pos_direct", 64'(a_imm), 64'h0000_6DB9);
        cycle("imm_andi", mk(OP_ANDI, 5'd1, 5'd2, 16'h8001), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);

        cycle("flush_lw", mk(OP_LW, 5'd1, 5'd2, 16'h10), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        cycle("flush_stall", mk(OP_R, 5'd6, 5'd2, 16'h0), 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1, 1'b0);
        cycle("after", mk(OP_LW, 5'd1, 5'd2, 16'h10), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 8)];
            cycle("rand", mk(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
                             16'($urandom)),
                  1'($urandom), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0), 1'b0);
        end
        check_rf("rand");

        cycle("midrst", mk(OP_R, 5'd3, 5'd4, 16'h0), 1'b1, 5'd5, 32'h77, 1'b0, 5'd0, 1'b0, 1'b1);
        check_rf("midrst");
        cycle("post", mk(OP_ADDI, 5'd3, 5'd4, 16'h7), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
